// File: rtl/tinyml_tree_pkg.sv
// Shared definitions for the decision-tree traversal controllers:
// node word field layout, leaf tag, result error codes and FSM states.
package tinyml_tree_pkg;

   localparam int NODE_ID_LSB = 96;
   localparam int FEAT_LSB    = 92;
   localparam int FEAT_W      = 4;
   localparam int THR_LSB     = 28;
   localparam int THR_W       = 64;
   localparam int LEFT_LSB    = 16;
   localparam int RIGHT_LSB   = 4;
   localparam int CLASS_LSB   = 0;
   localparam int CLASS_W     = 4;

   localparam logic [3:0] LEAF_TAG = 4'h3;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_DEPTH = 2'b01;
   localparam logic [1:0] ERR_ID    = 2'b10;
   localparam logic [1:0] ERR_CHILD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EVAL,
      ST_DONE,
      ST_ERR
   } tree_state_e;

   function automatic logic is_leaf(input logic [FEAT_W-1:0] feat_sel);
      return feat_sel == LEAF_TAG;
   endfunction

endpackage

// File: rtl/fp64_le_cmp.sv
// Combinational a <= b on IEEE-754 binary64 in total order, except that
// -0 equals +0 and any NaN operand yields 0 (caller steers right).
module fp64_le_cmp (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        le
);

   logic        a_nan, b_nan;
   logic [62:0] a_mag, b_mag;

   assign a_mag = a[62:0];
   assign b_mag = b[62:0];
   assign a_nan = (&a[62:52]) && (|a[51:0]);
   assign b_nan = (&b[62:52]) && (|b[51:0]);

   always_comb begin
      le = 1'b0;
      if (a_nan || b_nan) begin
         le = 1'b0;
      end else if (a_mag == '0 && b_mag == '0) begin
         le = 1'b1;
      end else if (a[63] != b[63]) begin
         le = a[63];
      end else if (!a[63]) begin
         le = (a_mag <= b_mag);
      end else begin
         // both negative: larger magnitude is the smaller number
         le = (a_mag >= b_mag);
      end
   end

endmodule

// File: rtl/tree_traversal_ctrl.sv
// Walks one decision-tree node ROM from root to leaf for a latched feature
// vector, two cycles per node (FETCH issues the read, EVAL consumes it).
module tree_traversal_ctrl
   import tinyml_tree_pkg::*;
#(
   parameter int NODE_WIDTH = 120,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_FEAT   = 16,
   parameter int MAX_DEPTH  = 32,
   parameter int ROOT_ADDR  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic [NUM_FEAT*64-1:0]   sample_features,
   output logic [ADDR_WIDTH-1:0]    rom_addr,
   input  logic [NODE_WIDTH-1:0]    rom_data,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic [3:0]               result_class,
   output logic [5:0]               result_depth,
   output logic [1:0]               result_err,
   output logic                     busy
);

   localparam logic [ADDR_WIDTH-1:0] ROOT = ADDR_WIDTH'(ROOT_ADDR);

   tree_state_e             state_q, state_d;
   logic [NUM_FEAT*64-1:0]  feats_q;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [5:0]              depth_q, depth_d;
   logic [3:0]              class_q, class_d;
   logic [1:0]              err_q, err_d;
   logic                    load_sample;

   logic [ADDR_WIDTH-1:0]   node_addr;
   logic [FEAT_W-1:0]       feat_sel;
   logic [THR_W-1:0]        threshold;
   logic [ADDR_WIDTH-1:0]   left_addr, right_addr, child_addr;
   logic [CLASS_W-1:0]      leaf_class;
   logic [63:0]             feat_val;
   logic                    go_left;
   logic                    unused_rom;

   // Node ids and child pointers are only meaningful in their low ADDR_WIDTH bits.
   assign node_addr  = rom_data[NODE_ID_LSB +: ADDR_WIDTH];
   assign feat_sel   = rom_data[FEAT_LSB +: FEAT_W];
   assign threshold  = rom_data[THR_LSB +: THR_W];
   assign left_addr  = rom_data[LEFT_LSB +: ADDR_WIDTH];
   assign right_addr = rom_data[RIGHT_LSB +: ADDR_WIDTH];
   assign leaf_class = rom_data[CLASS_LSB +: CLASS_W];
   assign unused_rom = ^rom_data;

   always_comb begin
      feat_val = '0;
      for (int f = 0; f < NUM_FEAT; f++) begin
         if (int'(feat_sel) == f) feat_val = feats_q[f*64 +: 64];
      end
   end

   fp64_le_cmp u_cmp (
      .a  (feat_val),
      .b  (threshold),
      .le (go_left)
   );

   assign child_addr = go_left ? left_addr : right_addr;

   // Handshakes: a sample transfers on a clock edge where sample_valid and
   // sample_ready are both high; a result transfers where result_valid and
   // result_ready are both high. Ready never waits on valid, and the result
   // fields hold still for as long as result_valid is high.
   assign sample_ready = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign result_valid = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign result_class = class_q;
   assign result_depth = depth_q;
   assign result_err   = err_q;
   assign rom_addr     = addr_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      depth_d     = depth_q;
      class_d     = class_q;
      err_d       = err_q;
      load_sample = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               load_sample = 1'b1;
               addr_d      = ROOT;
               depth_d     = '0;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            depth_d = depth_q + 6'd1;
            if (node_addr != addr_q) begin
               state_d = ST_ERR;
               err_d   = ERR_ID;
               class_d = '0;
            end else if (is_leaf(feat_sel)) begin
               state_d = ST_DONE;
               err_d   = ERR_OK;
               class_d = leaf_class;
            end else if (int'(depth_d) == MAX_DEPTH) begin
               state_d = ST_ERR;
               err_d   = ERR_DEPTH;
               class_d = '0;
            end else if (int'(feat_sel) >= NUM_FEAT || child_addr == '0) begin
               // a zero child would loop back to the root
               state_d = ST_ERR;
               err_d   = ERR_CHILD;
               class_d = '0;
            end else begin
               addr_d  = child_addr;
               state_d = ST_FETCH;
            end
         end
         ST_DONE, ST_ERR: begin
            if (result_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= ROOT;
         depth_q <= '0;
         class_q <= '0;
         err_q   <= '0;
         feats_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         depth_q <= depth_d;
         class_q <= class_d;
         err_q   <= err_d;
         if (load_sample) feats_q <= sample_features;
      end
   end

endmodule
